// File: rtl/ultrasonic_echo_model_if.sv
// Trigger/echo signal bundle between a ranging controller (master) and the
// ultrasonic echo model (slave).
interface ultrasonic_echo_model_if;
  logic       trig;
  logic [8:0] dist_cm;
  logic       echo;
  logic       busy;
  logic       short_trig;
  logic [7:0] meas_cnt;

  modport master (
    output trig,
    output dist_cm,
    input  echo,
    input  busy,
    input  short_trig,
    input  meas_cnt
  );

  modport slave (
    input  trig,
    input  dist_cm,
    output echo,
    output busy,
    output short_trig,
    output meas_cnt
  );
endinterface

// File: rtl/ultrasonic_echo_model.sv
// Timing model of an ultrasonic ranger: validates a trigger pulse, waits the burst
// time, then answers with an echo pulse whose width encodes the emulated distance.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   IDLE    | waiting for a fresh trigger rising edge
//   TRIG_HI | trigger high, measuring its width
//   BURST   | emulated burst flight time before the echo
//   ECHO    | echo output high for the latched length
//   HOLDOFF | dead time, trigger activity ignored
module ultrasonic_echo_model #(
  parameter int TRIG_MIN_CYC = 500,
  parameter int BURST_CYC    = 10000,
  parameter int CYC_PER_CM   = 2900,
  parameter int MAX_CM       = 400,
  parameter int TIMEOUT_CYC  = 1900000,
  parameter int HOLDOFF_CYC  = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  ultrasonic_echo_model_if.slave bus
);

  localparam int TW = 22;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  state_t        state, state_nx;
  logic          sync1, trig_s, trig_d;
  logic [1:0]    sync_vld;
  logic          armed;
  logic          trig_rise, trig_fall;
  logic [TW-1:0] width, width_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic [TW-1:0] len, len_nx;
  logic [TW-1:0] len_calc;
  logic [TW-1:0] dist_ext;
  logic          echo_q, busy_q, short_q, short_nx;
  logic [7:0]    meas_q, meas_nx;

  // The synchronizer flops come out of reset low, so a trigger held high across
  // reset would look like a rising edge; armed waits for a genuine low sample first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      trig_s   <= 1'b0;
      trig_d   <= 1'b0;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      sync1    <= bus.trig;
      trig_s   <= sync1;
      trig_d   <= trig_s;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && !trig_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign trig_rise = armed && trig_s && !trig_d;
  assign trig_fall = !trig_s && trig_d;

  assign dist_ext = {{(TW-9){1'b0}}, bus.dist_cm};

  always_comb begin
    if (bus.dist_cm == 9'd0 || dist_ext > TW'(MAX_CM)) begin
      len_calc = TW'(TIMEOUT_CYC);
    end else begin
      len_calc = dist_ext * TW'(CYC_PER_CM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    width_nx = width;
    tmr_nx   = tmr;
    len_nx   = len;
    meas_nx  = meas_q;
    short_nx = 1'b0;
    case (state)
      IDLE: begin
        if (trig_rise) begin
          state_nx = TRIG_HI;
          width_nx = TW'(1);
        end
      end
      TRIG_HI: begin
        if (trig_fall) begin
          if (width >= TW'(TRIG_MIN_CYC)) begin
            state_nx = BURST;
            len_nx   = len_calc;
            tmr_nx   = TW'(BURST_CYC - 1);
          end else begin
            state_nx = IDLE;
            short_nx = 1'b1;
          end
        end else if (trig_s && width < TW'(TRIG_MIN_CYC)) begin
          width_nx = width + 1'b1;
        end
      end
      BURST: begin
        if (tmr == '0) begin
          state_nx = ECHO;
          tmr_nx   = len - 1'b1;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      ECHO: begin
        if (tmr == '0) begin
          state_nx = HOLDOFF;
          tmr_nx   = TW'(HOLDOFF_CYC - 1);
          meas_nx  = meas_q + 8'd1;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      HOLDOFF: begin
        if (tmr == '0) begin
          state_nx = IDLE;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width   <= '0;
      tmr     <= '0;
      len     <= '0;
      meas_q  <= 8'd0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      width   <= width_nx;
      tmr     <= tmr_nx;
      len     <= len_nx;
      meas_q  <= meas_nx;
      echo_q  <= (state_nx == ECHO);
      busy_q  <= (state_nx != IDLE);
      short_q <= short_nx;
    end
  end

  assign bus.echo       = echo_q;
  assign bus.busy       = busy_q;
  assign bus.short_trig = short_q;
  assign bus.meas_cnt   = meas_q;

endmodule

// File: tb/tb_ultrasonic_echo_model.sv
// Directed plus randomized bench for ultrasonic_echo_model with a cycle-level
// reference model of trigger acceptance, echo timing and measurement count.
module tb_ultrasonic_echo_model;

  localparam int TRIG_MIN_CYC = 5;
  localparam int BURST_CYC    = 10;
  localparam int CYC_PER_CM   = 3;
  localparam int MAX_CM       = 400;
  localparam int TIMEOUT_CYC  = 2000;
  localparam int HOLDOFF_CYC  = 20;
  localparam int SYNC_LAT     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ultrasonic_echo_model_if bus();

  ultrasonic_echo_model #(
    .TRIG_MIN_CYC (TRIG_MIN_CYC),
    .BURST_CYC    (BURST_CYC),
    .CYC_PER_CM   (CYC_PER_CM),
    .MAX_CM       (MAX_CM),
    .TIMEOUT_CYC  (TIMEOUT_CYC),
    .HOLDOFF_CYC  (HOLDOFF_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Event observer: cumulative counters, last edge times.
  int   rise_cyc = 0, fall_cyc = 0, busy_fall_cyc = 0;
  int   echo_pulses = 0, short_cnt = 0, busy_seen = 0;
  logic prev_echo = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (bus.echo && !prev_echo) begin
      rise_cyc = cyc;
      echo_pulses++;
    end
    if (!bus.echo && prev_echo) fall_cyc = cyc;
    if (!bus.busy && prev_busy) busy_fall_cyc = cyc;
    if (bus.short_trig) short_cnt++;
    if (bus.busy) busy_seen++;
    prev_echo = bus.echo;
    prev_busy = bus.busy;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_meas = 8'd0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_len(input int d);
    if (d == 0 || d > MAX_CM) return TIMEOUT_CYC;
    return d * CYC_PER_CM;
  endfunction

  // One trigger pulse of hi cycles at distance d; optional extra trigger poke and
  // mid-measurement distance change, offsets counted from the trigger fall.
  task automatic shot(input int hi, input int d, input int poke_at, input int poke_len,
                      input int dmid_at, input int dmid);
    int p0, s0, f_in;
    bit done;
    p0 = echo_pulses;
    s0 = short_cnt;
    bus.dist_cm = 9'(d);
    @(posedge clk); #1;
    bus.trig = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
    bus.trig = 1'b0;
    f_in = cyc;
    done = 1'b0;
    for (int k = 1; k <= 2500; k++) begin
      @(posedge clk); #1;
      if (k == poke_at) bus.trig = 1'b1;
      if (k == poke_at + poke_len) bus.trig = 1'b0;
      if (k == dmid_at) bus.dist_cm = 9'(dmid);
      if (k > 4 && !bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    bus.trig = 1'b0;
    @(negedge clk); #1;
    chk("shot_done", int'(done), 1);
    if (hi >= TRIG_MIN_CYC) begin
      exp_meas++;
      chk("echo_pulses", echo_pulses - p0, 1);
      chk("echo_delay", rise_cyc - f_in, SYNC_LAT + 1 + BURST_CYC);
      chk("echo_width", fall_cyc - rise_cyc, model_len(d));
      chk("holdoff", busy_fall_cyc - fall_cyc, HOLDOFF_CYC);
      chk("short_on_valid", short_cnt - s0, 0);
    end else begin
      chk("short_pulse", short_cnt - s0, 1);
      chk("echo_on_short", echo_pulses - p0, 0);
    end
    chk("meas_cnt", int'(bus.meas_cnt), int'(exp_meas));
  endtask

  initial begin
    int  b0, p0, hi, d;
    bit  seen;
    bus.trig    = 1'b0;
    bus.dist_cm = 9'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_echo", int'(bus.echo), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_short", int'(bus.short_trig), 0);
    chk("reset_meas", int'(bus.meas_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // 256 back-to-back measurements: counter wraps to zero
    for (int i = 0; i < 256; i++) begin
      shot(TRIG_MIN_CYC + (i % 3), 1 + (i % 5), 0, 0, 0, 0);
    end
    chk("meas_wrap", int'(bus.meas_cnt), 0);

    shot(8, 100, 0, 0, 0, 0);
    shot(3, 100, 0, 0, 0, 0);
    shot(TRIG_MIN_CYC - 1, 50, 0, 0, 0, 0);
    shot(TRIG_MIN_CYC, 50, 0, 0, 0, 0);
    shot(1, 50, 0, 0, 0, 0);

    shot(8, 0, 0, 0, 0, 0);
    shot(8, 401, 0, 0, 0, 0);
    shot(8, 400, 0, 0, 0, 0);
    shot(8, 1, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      hi = int'($urandom_range(10, 1));
      d  = int'($urandom_range(511, 0));
      shot(hi, d, 0, 0, 0, 0);
    end

    // Extra trigger activity in BURST, ECHO and HOLDOFF; distance change mid-BURST
    shot(8, 100, 5, 6, 0, 0);
    shot(8, 100, 50, 6, 0, 0);
    shot(8, 100, 100, 2, 0, 0);
    shot(8, 100, 318, 6, 0, 0);
    shot(8, 100, 0, 0, 6, 250);

    // Reset in the middle of an echo, trigger held high across release
    bus.dist_cm = 9'd100;
    @(posedge clk); #1;
    bus.trig = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    bus.trig = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.echo) begin
        seen = 1'b1;
        break;
      end
    end
    chk("echo_before_rst", int'(seen), 1);
    repeat (50) @(posedge clk);
    #3;
    rst      = 1'b1;
    bus.trig = 1'b1;
    #1;
    chk("rst_echo", int'(bus.echo), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_short", int'(bus.short_trig), 0);
    chk("rst_meas", int'(bus.meas_cnt), 0);
    exp_meas = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b0 = busy_seen;
    p0 = echo_pulses;
    repeat (60) @(posedge clk);
    @(negedge clk); #1;
    chk("held_trig_busy", busy_seen - b0, 0);
    chk("held_trig_echo", echo_pulses - p0, 0);
    chk("held_trig_meas", int'(bus.meas_cnt), 0);
    bus.trig = 1'b0;
    repeat (4) @(posedge clk);
    shot(8, 77, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
